// File: rtl/dsp_mac_pipe.sv
// Flow-controlled pre-add / multiply / post-add MAC pipeline (DSP48A1 successor).
// Three valid/ready stages advance together; the stage-3 register doubles as the accumulator.
module dsp_mac_pipe #(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 48,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               RSTN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [B_WIDTH-1:0] D,
  input  logic [P_WIDTH-1:0] C,
  input  logic [4:0]         OPMODE,
  input  logic               CARRYIN,
  input  logic               ACC_CLR,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] P,
  output logic               CARRYOUT,
  output logic               OVERFLOW
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_ADDC  = 3'b001,
    OP_SUBC  = 3'b010,
    OP_ACC   = 3'b011,
    OP_DEC   = 3'b100,
    OP_PASSC = 3'b101
  } post_op_e;

  logic                      w_adv;
  logic                      r_s1_valid;
  logic signed [A_WIDTH-1:0] r_s1_a;
  logic signed [B_WIDTH-1:0] r_s1_b;
  logic signed [B_WIDTH-1:0] r_s1_d;
  logic        [P_WIDTH-1:0] r_s1_c;
  logic        [4:0]         r_s1_op;
  logic                      r_s1_ci;
  logic                      r_s1_clr;

  logic signed [B_WIDTH-1:0] w_bp;
  logic signed [M_WIDTH-1:0] w_m;

  logic                      r_s2_valid;
  logic signed [M_WIDTH-1:0] r_s2_m;
  logic        [P_WIDTH-1:0] r_s2_c;
  post_op_e                  r_s2_post;
  logic                      r_s2_ci;
  logic                      r_s2_clr;

  logic                      r_out_valid;
  logic        [P_WIDTH-1:0] r_p;
  logic                      r_co;
  logic                      r_ov;

  logic signed [P_WIDTH-1:0] w_ms;
  logic        [P_WIDTH-1:0] w_pa;
  logic        [P_WIDTH-1:0] w_x;
  logic                      w_is_add;
  logic                      w_is_sub;
  logic                      w_cin;
  logic        [P_WIDTH:0]   w_add;
  logic        [P_WIDTH:0]   w_sub;
  logic        [P_WIDTH-1:0] w_res;
  logic                      w_co;
  logic                      w_ov;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  assign out_valid = r_out_valid;
  assign P         = r_p;
  assign CARRYOUT  = r_co;
  assign OVERFLOW  = r_ov;

  assign w_bp = r_s1_op[4] ? (r_s1_op[3] ? r_s1_d - r_s1_b : r_s1_d + r_s1_b) : r_s1_b;
  assign w_m  = M_WIDTH'(r_s1_a) * M_WIDTH'(w_bp);
  assign w_ms = P_WIDTH'(r_s2_m);
  assign w_pa = r_s2_clr ? '0 : r_p;

  always_comb begin
    w_x      = '0;
    w_is_add = 1'b0;
    w_is_sub = 1'b0;
    w_cin    = 1'b0;
    case (r_s2_post)
      OP_ADDC: begin w_x = r_s2_c; w_is_add = 1'b1; w_cin = r_s2_ci; end
      OP_SUBC: begin w_x = r_s2_c; w_is_sub = 1'b1; end
      OP_ACC:  begin w_x = w_pa;   w_is_add = 1'b1; end
      OP_DEC:  begin w_x = w_pa;   w_is_sub = 1'b1; end
      default: ;
    endcase

    w_add = {1'b0, w_x} + {1'b0, w_ms} + {{P_WIDTH{1'b0}}, w_cin};
    w_sub = {1'b0, w_x} - {1'b0, w_ms};

    w_res = w_ms;
    w_co  = 1'b0;
    w_ov  = 1'b0;
    if (w_is_add) begin
      w_res = w_add[P_WIDTH-1:0];
      w_co  = w_add[P_WIDTH];
      w_ov  = (w_x[P_WIDTH-1] == w_ms[P_WIDTH-1]) && (w_add[P_WIDTH-1] != w_x[P_WIDTH-1]);
    end else if (w_is_sub) begin
      w_res = w_sub[P_WIDTH-1:0];
      w_co  = !w_sub[P_WIDTH];
      w_ov  = (w_x[P_WIDTH-1] != w_ms[P_WIDTH-1]) && (w_sub[P_WIDTH-1] != w_x[P_WIDTH-1]);
    end else if (r_s2_post == OP_PASSC) begin
      w_res = r_s2_c;
    end

    // On overflow the true result always carries the sign of the first operand.
    if ((SATURATE != 0) && w_ov)
      w_res = w_x[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_d      <= '0;
      r_s1_c      <= '0;
      r_s1_op     <= '0;
      r_s1_ci     <= 1'b0;
      r_s1_clr    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_m      <= '0;
      r_s2_c      <= '0;
      r_s2_post   <= OP_MUL;
      r_s2_ci     <= 1'b0;
      r_s2_clr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_co        <= 1'b0;
      r_ov        <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= A;
      r_s1_b     <= B;
      r_s1_d     <= D;
      r_s1_c     <= C;
      r_s1_op    <= OPMODE;
      r_s1_ci    <= CARRYIN;
      r_s1_clr   <= ACC_CLR;

      r_s2_valid <= r_s1_valid;
      r_s2_m     <= w_m;
      r_s2_c     <= r_s1_c;
      r_s2_post  <= post_op_e'(r_s1_op[2:0]);
      r_s2_ci    <= r_s1_ci;
      r_s2_clr   <= r_s1_clr;

      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_p  <= w_res;
        r_co <= w_co;
        r_ov <= w_ov;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a wrapping and a saturating instance run in lockstep
// through a vector table, then accumulate, backpressure and reset-mid-stream sequences.
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        RSTN;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [17:0] A, B, D;
  logic [47:0] C;
  logic [4:0]  OPMODE;
  logic        CARRYIN, ACC_CLR;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [47:0] P, P_s;
  logic        CARRYOUT, CARRYOUT_s, OVERFLOW, OVERFLOW_s;

  int n_pass  = 0;
  int n_total = 0;
  logic [47:0] q[$];

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(0)) dut (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .CARRYIN(CARRYIN), .ACC_CLR(ACC_CLR),
    .out_valid(out_valid), .out_ready(out_ready), .P(P), .CARRYOUT(CARRYOUT), .OVERFLOW(OVERFLOW)
  );

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(1)) dut_sat (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .CARRYIN(CARRYIN), .ACC_CLR(ACC_CLR),
    .out_valid(out_valid_s), .out_ready(out_ready), .P(P_s), .CARRYOUT(CARRYOUT_s), .OVERFLOW(OVERFLOW_s)
  );

  // Every delivered result (handshake at the following rising edge).
  always @(negedge clk)
    if (RSTN && out_valid && out_ready) q.push_back(P);

  typedef struct {
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [4:0]  op;
    logic        ci, clr;
    logic [47:0] exp_p;
    logic        exp_co, exp_ov;
    logic [47:0] exp_ps;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push();
    int   g;
    logic acc;
    g = 0;
    in_valid = 1'b1;
    do begin
      #1 acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 50);
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_in(input logic [17:0] a, input logic [17:0] b, input logic [4:0] op, input logic clr);
    A = a; B = b; D = '0; C = '0; OPMODE = op; CARRYIN = 1'b0; ACC_CLR = clr;
  endtask

  initial begin
    //          a        b        d      c                   op        ci    clr   exp_p               co    ov    exp_ps
    vecs[0]  = '{18'd3,  18'd5,  18'd0, 48'd0,              5'b00000, 1'b1, 1'b0, 48'd15,             1'b0, 1'b0, 48'd15};
    vecs[1]  = '{18'd3,  18'd5,  18'd2, 48'd0,              5'b10000, 1'b0, 1'b0, 48'd21,             1'b0, 1'b0, 48'd21};
    vecs[2]  = '{18'd3,  18'd5,  18'd2, 48'd0,              5'b11000, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF7, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF7};
    vecs[3]  = '{-18'd2, 18'd4,  18'd0, 48'd0,              5'b00000, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF8, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF8};
    vecs[4]  = '{18'd1,  18'd1,  18'd0, 48'hFFFF_FFFF_FFFF, 5'b00001, 1'b0, 1'b0, 48'd0,              1'b1, 1'b0, 48'd0};
    vecs[5]  = '{18'd1,  18'd1,  18'd0, 48'h7FFF_FFFF_FFFF, 5'b00001, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1, 48'h7FFF_FFFF_FFFF};
    vecs[6]  = '{18'd3,  18'd5,  18'd0, 48'd100,            5'b00010, 1'b0, 1'b1, 48'd85,             1'b1, 1'b0, 48'd85};
    vecs[7]  = '{18'd3,  18'd5,  18'd0, 48'd5,              5'b00010, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF6, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF6};
    vecs[8]  = '{18'd3,  18'd3,  18'd0, 48'h1234,           5'b00101, 1'b0, 1'b0, 48'h1234,           1'b0, 1'b0, 48'h1234};
    vecs[9]  = '{18'd2,  18'd3,  18'd0, 48'd10,             5'b00001, 1'b1, 1'b0, 48'd17,             1'b0, 1'b0, 48'd17};
    vecs[10] = '{18'd7,  18'd6,  18'd0, 48'd99,             5'b00110, 1'b0, 1'b0, 48'd42,             1'b0, 1'b0, 48'd42};
    vecs[11] = '{18'd1,  18'd1,  18'd0, 48'h8000_0000_0000, 5'b00010, 1'b0, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1, 48'h8000_0000_0000};
    vecs[12] = '{-18'd3, 18'd4,  18'd0, 48'd0,              5'b00011, 1'b1, 1'b1, 48'hFFFF_FFFF_FFF4, 1'b0, 1'b0, 48'hFFFF_FFFF_FFF4};
    vecs[13] = '{18'd2,  -18'd3, 18'd0, 48'd0,              5'b00100, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFA, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFA};

    RSTN = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(18'd9, 18'd9, 5'b00000, 1'b0);
    step(); step();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_P", 64'(P), 64'd0);
    chk("reset_CARRYOUT", 64'(CARRYOUT), 64'd0);
    chk("reset_OVERFLOW", 64'(OVERFLOW), 64'd0);
    RSTN = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      A = vecs[i].a; B = vecs[i].b; D = vecs[i].d; C = vecs[i].c;
      OPMODE = vecs[i].op; CARRYIN = vecs[i].ci; ACC_CLR = vecs[i].clr;
      push();
      step();
      chk($sformatf("v%0d_valid_edge2", i), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("v%0d_valid_edge3", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_P", i), 64'(P), 64'(vecs[i].exp_p));
      chk($sformatf("v%0d_CARRYOUT", i), 64'(CARRYOUT), 64'(vecs[i].exp_co));
      chk($sformatf("v%0d_OVERFLOW", i), 64'(OVERFLOW), 64'(vecs[i].exp_ov));
      chk($sformatf("v%0d_P_sat", i), 64'(P_s), 64'(vecs[i].exp_ps));
      chk($sformatf("v%0d_OVERFLOW_sat", i), 64'(OVERFLOW_s), 64'(vecs[i].exp_ov));
    end

    // Back-to-back accumulate.
    step(); step();
    q.delete();
    set_in(18'd1, 18'd10, 5'b00011, 1'b1); push();
    set_in(18'd2, 18'd10, 5'b00011, 1'b0); push();
    set_in(18'd3, 18'd10, 5'b00011, 1'b0); push();
    repeat (5) step();
    chk("acc_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("acc_0", 64'(q[0]), 64'd10);
      chk("acc_1", 64'(q[1]), 64'd30);
      chk("acc_2", 64'(q[2]), 64'd60);
    end

    // Accumulate with a two-cycle input gap.
    q.delete();
    set_in(18'd1, 18'd10, 5'b00011, 1'b1); push();
    set_in(18'd2, 18'd10, 5'b00011, 1'b0); push();
    step(); step();
    set_in(18'd3, 18'd10, 5'b00011, 1'b0); push();
    repeat (5) step();
    chk("gap_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) chk("gap_final", 64'(q[2]), 64'd60);

    // Backpressure: five multiplies, consumer stalls for cycles 4..6.
    q.delete();
    begin
      int   nxt;
      logic acc;
      nxt = 0;
      for (int c = 0; c < 20; c++) begin
        out_ready = !(c >= 4 && c <= 6);
        in_valid  = (nxt < 5);
        set_in(18'(nxt + 1), 18'd7, 5'b00000, 1'b0);
        #1;
        if (c >= 4 && c <= 6) begin
          chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
          chk($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'd1);
          chk($sformatf("bp_P_hold_c%0d", c), 64'(P), 64'd14);
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) nxt++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    chk("bp_count", 64'(q.size()), 64'd5);
    if (q.size() == 5)
      for (int k = 0; k < 5; k++)
        chk($sformatf("bp_item%0d", k), 64'(q[k]), 64'(7 * (k + 1)));

    // Reset with two items in flight.
    q.delete();
    set_in(18'd5, 18'd5, 5'b00000, 1'b0); push();
    set_in(18'd6, 18'd6, 5'b00000, 1'b0); push();
    RSTN = 1'b0;
    step();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_P", 64'(P), 64'd0);
    RSTN = 1'b1;
    repeat (5) step();
    chk("rst_mid_dropped", 64'(q.size()), 64'd0);
    set_in(18'd4, 18'd1, 5'b00011, 1'b0); push();
    step(); step();
    chk("rst_acc_valid", 64'(out_valid), 64'd1);
    chk("rst_acc_P", 64'(P), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
